// File: rtl/ul_fifo_pkg.sv
// rtl/ul_fifo_pkg.sv - shared defaults and width helper for the sync FIFO slice
package ul_fifo_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 10;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit over the address.
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ul_sync_fifo_if.sv
// rtl/ul_sync_fifo_if.sv - write/read handshake and status bundle of the sync FIFO
interface ul_sync_fifo_if
  import ul_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                         wen;
  logic [DATA_W-1:0]            wdata;
  logic                         rden;
  logic [DATA_W-1:0]            rdata;
  logic                         rvalid;
  logic [count_w(ADDR_W)-1:0]   count;
  logic                         full;
  logic                         afull;
  logic                         empty;
  logic                         aempty;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output wen, wdata, rden,
    input  rdata, rvalid, count, full, afull, empty, aempty, overflow, underflow
  );

  modport slave (
    input  wen, wdata, rden,
    output rdata, rvalid, count, full, afull, empty, aempty, overflow, underflow
  );

endinterface

// File: rtl/ul_sdp_ram.sv
// rtl/ul_sdp_ram.sv - simple dual-port RAM, synchronous write, registered read-first read
module ul_sdp_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk_in,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Same-address collision returns the old word because both updates are non-blocking.
  always_ff @(posedge clk_in) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ul_sync_fifo.sv
// rtl/ul_sync_fifo.sv - single-clock FIFO: pointers, occupancy, registered flags around ul_sdp_ram
module ul_sync_fifo
  import ul_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = 1020,
  parameter int AEMPTY_TH = 4,
  parameter int ZERO_IDLE = 1
) (
  input  logic           clk_in,
  input  logic           rst,
  ul_sync_fifo_if.slave  fifo
);

  localparam int CNT_W = count_w(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              full_q, afull_q, empty_q, aempty_q;
  logic              ovf_q, unf_q, rvalid_q;
  logic [DATA_W-1:0] ram_rdata, hold_q;
  logic              r_acc, w_acc;

  assign r_acc = fifo.rden & ~empty_q & ~rst;
  assign w_acc = fifo.wen & (~full_q | r_acc) & ~rst;

  always_comb begin
    count_next = count_q;
    if (w_acc && !r_acc)
      count_next = count_q + CNT_W'(1);
    else if (!w_acc && r_acc)
      count_next = count_q - CNT_W'(1);
  end

  // Flags come from count_next so they move on the same edge as count; pointers never compared.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (w_acc) wptr <= wptr + ADDR_W'(1);
      if (r_acc) rptr <= rptr + ADDR_W'(1);
      count_q  <= count_next;
      full_q   <= (count_next == DEPTH_C);
      afull_q  <= (count_next >= AFULL_C);
      empty_q  <= (count_next == '0);
      aempty_q <= (count_next <= AEMPTY_C);
      ovf_q    <= fifo.wen & ~w_acc;
      unf_q    <= fifo.rden & ~r_acc;
      rvalid_q <= r_acc;
    end
  end

  // Idle-cycle rdata: stays zero when ZERO_IDLE, otherwise the last delivered word.
  always_ff @(posedge clk_in) begin
    if (rst)
      hold_q <= '0;
    else if (rvalid_q && ZERO_IDLE == 0)
      hold_q <= ram_rdata;
  end

  ul_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_in (clk_in),
    .wen    (w_acc),
    .waddr  (wptr),
    .wdata  (fifo.wdata),
    .ren    (r_acc),
    .raddr  (rptr),
    .rdata  (ram_rdata)
  );

  assign fifo.rdata     = rvalid_q ? ram_rdata : hold_q;
  assign fifo.rvalid    = rvalid_q;
  assign fifo.count     = count_q;
  assign fifo.full      = full_q;
  assign fifo.afull     = afull_q;
  assign fifo.empty     = empty_q;
  assign fifo.aempty    = aempty_q;
  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = unf_q;

endmodule
